// File: rtl/sdb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sdb_seq_ctrl
//
// Sequences one TOT_W-bit addition (a + b + c_in) through a single SLICE_W-bit
// self-dual adder slice (sdb), one slice per clock, least significant first.
// The sdb carries a complementary second rail; any disagreement between the
// rails during an operation raises a sticky err flag.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a, b, c_in are offered
//   in_ready   : block accepts an operation this cycle (IDLE only)
//   a, b       : TOT_W-bit operands
//   c_in       : carry-in
//   out_valid  : sum, c_out, err are valid (DONE only)
//   out_ready  : consumer takes the result
//   sum        : (a + b + c_in) mod 2^TOT_W
//   c_out      : carry-out of the full addition
//   err        : slice self-check failed at least once in this operation
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sdb : SLICE_W-bit ripple adder slice with a complementary check rail.
//
// Rail 1 adds a, b, c_in directly. Rail 2 adds the complemented operands;
// since a full adder is self-dual, rail 2 must produce ~s1 and ~c_out_1.
// c_out_2 is re-inverted so a healthy slice gives c_out_1 == c_out_2 and
// s1 == ~s2.
//
// Ports
//   a, b    : slice operands
//   c_in    : slice carry-in
//   p       : propagate vector, a ^ b (shared by both rails)
//   s1      : true-rail sum
//   s2      : complement-rail sum (expected ~s1)
//   c_out_1 : true-rail carry-out
//   c_out_2 : complement-rail carry-out, re-inverted (expected c_out_1)
// ---------------------------------------------------------------------------
module sdb #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic [W-1:0] p,
    output logic [W-1:0] s1,
    output logic [W-1:0] s2,
    output logic         c_out_1,
    output logic         c_out_2
);

    logic [W:0] c_t;  // true-rail carry chain
    logic [W:0] c_n;  // complement-rail carry chain

    always_comb begin
        c_t    = '0;
        c_n    = '0;
        s1     = '0;
        s2     = '0;
        c_t[0] = c_in;
        c_n[0] = ~c_in;
        for (int i = 0; i < W; i++) begin
            s1[i]    = p[i] ^ c_t[i];
            c_t[i+1] = (a[i] & b[i]) | (p[i] & c_t[i]);
            // (~a) ^ (~b) == p, so the propagate term is shared
            s2[i]    = p[i] ^ c_n[i];
            c_n[i+1] = (~a[i] & ~b[i]) | (p[i] & c_n[i]);
        end
        c_out_1 = c_t[W];
        c_out_2 = ~c_n[W];
    end

endmodule

module sdb_seq_ctrl #(
    parameter int SLICE_W  = 8,
    parameter int N_SLICES = 4,
    localparam int TOT_W   = SLICE_W * N_SLICES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TOT_W-1:0] a,
    input  logic [TOT_W-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TOT_W-1:0] sum,
    output logic             c_out,
    output logic             err
);

    localparam int K_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [TOT_W-1:0]   a_q, a_d;
    logic [TOT_W-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [TOT_W-1:0]   sum_q, sum_d;
    logic               err_q, err_d;
    // Holds in_ready low while reset is asserted; goes high at the first
    // edge after release.
    logic               live_q, live_d;

    logic [SLICE_W-1:0] sl_a, sl_b, sl_p, sl_s1, sl_s2;
    logic               sl_co1, sl_co2;
    int                 sl_off;

    // Slice operands come only from the captured registers, never from the
    // live input ports.
    always_comb begin
        sl_off = int'(k_q) * SLICE_W;
        sl_a   = a_q[sl_off +: SLICE_W];
        sl_b   = b_q[sl_off +: SLICE_W];
        sl_p   = sl_a ^ sl_b;
    end

    sdb #(
        .W (SLICE_W)
    ) u_sdb (
        .a       (sl_a),
        .b       (sl_b),
        .c_in    (carry_q),
        .p       (sl_p),
        .s1      (sl_s1),
        .s2      (sl_s2),
        .c_out_1 (sl_co1),
        .c_out_2 (sl_co2)
    );

    assign in_ready  = (state_q == IDLE) & live_q;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = carry_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        err_d   = err_q;
        live_d  = 1'b1;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    sum_d   = '0;
                    err_d   = 1'b0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[sl_off +: SLICE_W] = sl_s1;
                carry_d = sl_co1;
                if ((sl_co1 != sl_co2) || (sl_s1 != ~sl_s2)) begin
                    err_d = 1'b1;
                end
                // k parks on the last slice instead of wrapping
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

endmodule

// File: tb/tb_sdb_seq_ctrl.sv
module tb_sdb_seq_ctrl;

    localparam int SLICE_W  = 8;
    localparam int N_SLICES = 4;
    localparam int TOT_W    = SLICE_W * N_SLICES;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [TOT_W-1:0] a = '0;
    logic [TOT_W-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [TOT_W-1:0] sum;
    logic             c_out;
    logic             err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdb_seq_ctrl #(
        .SLICE_W  (SLICE_W),
        .N_SLICES (N_SLICES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the whole addition in one step.
    function automatic logic [TOT_W:0] model(input logic [TOT_W-1:0] x, input logic [TOT_W-1:0] y,
                                             input logic ci);
        return {1'b0, x} + {1'b0, y} + {{TOT_W{1'b0}}, ci};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, 64'(in_ready), 64'd1);
    endtask

    // One full operation: accept, latency, result, hold with out_ready=0,
    // then the release handshake with a competing in_valid.
    task automatic do_op(input logic [TOT_W-1:0] xa, input logic [TOT_W-1:0] xb,
                         input logic ci, input int hold, input string tag);
        logic [TOT_W:0] exp;
        int n;
        exp = model(xa, xb, ci);
        wait_ready({tag, ".rdy"});
        a = xa; b = xb; c_in = ci; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c_in = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            chk({tag, ".busy_rdy"}, 64'(in_ready), 64'd0);
            cyc();
            n++;
        end
        chk({tag, ".lat"}, 64'(n), 64'(N_SLICES));
        chk({tag, ".sum"}, 64'(sum), 64'(exp[TOT_W-1:0]));
        chk({tag, ".cout"}, 64'(c_out), 64'(exp[TOT_W]));
        chk({tag, ".err"}, 64'(err), 64'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            a = $urandom; b = $urandom; c_in = 1'($urandom);
            cyc();
            chk({tag, ".hold_res"}, {31'd0, err, c_out, sum}, {31'd0, 1'b0, exp});
            chk({tag, ".hold_vld"}, {62'd0, out_valid, in_ready}, {62'd0, 2'b10});
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        cyc();
        // back in IDLE without having taken the competing in_valid
        chk({tag, ".rel"}, {62'd0, out_valid, in_ready}, {62'd0, 2'b01});
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    logic [TOT_W:0]   q_exp[$];
    int               last_acc;
    logic [TOT_W:0]   e;

    initial begin
        // reset state
        #2;
        chk("rst.outs", {29'd0, in_ready, out_valid, err, c_out, sum}, 64'd0);
        cyc();
        cyc();
        chk("rst.held_rdy", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.rel_rdy", 64'(in_ready), 64'd0);
        cyc();
        chk("rst.first_edge_rdy", 64'(in_ready), 64'd1);

        // directed cases
        do_op(32'hFFFFFFFF, 32'h0, 1'b1, 0, "ffff");
        do_op(32'h12345678, 32'h0FEDCBA9, 1'b0, 2, "mix");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 10, "hold10");
        do_op(32'h0, 32'h0, 1'b0, 0, "zero");

        // reset in RUN with k=2
        wait_ready("ab.rdy");
        a = 32'h11111111; b = 32'h22222222; c_in = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("ab.partial", 64'(sum), 64'h3333);
        rst_n = 1'b0;
        #1;
        chk("ab.outs", {29'd0, in_ready, out_valid, err, c_out, sum}, 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("ab.rel_rdy", 64'(in_ready), 64'd0);
        cyc();
        chk("ab.first_rdy", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("ab.no_vld", 64'(out_valid), 64'd0);
        end
        do_op(32'hDEADBEEF, 32'h21524111, 1'b1, 1, "after_ab");

        // back-to-back
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = $urandom; b = $urandom; c_in = 1'($urandom);
        last_acc = -1;
        for (int t = 0; t < 80; t++) begin
            if (t == 60) in_valid = 1'b0;
            if (in_valid && in_ready) begin
                q_exp.push_back(model(a, b, c_in));
                if (last_acc >= 0) chk("b2b.period", 64'(t - last_acc), 64'(N_SLICES + 2));
                last_acc = t;
            end
            if (out_valid) begin
                if (q_exp.size() == 0) begin
                    chk("b2b.spurious", 64'd1, 64'd0);
                end else begin
                    e = q_exp.pop_front();
                    chk("b2b.res", {31'd0, err, c_out, sum}, {31'd0, 1'b0, e});
                end
            end
            cyc();
            a = $urandom; b = $urandom; c_in = 1'($urandom);
        end
        chk("b2b.drained", 64'(q_exp.size()), 64'd0);
        out_ready = 1'b0;
        in_valid = 1'b0;

        // random operands
        for (int i = 0; i < 1000; i++) begin
            do_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdb_seq_ctrl.md
SDB_SEQ_CTRL -- requirements
Module: sdb_seq_ctrl

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 8, the width of the single sdb slice it sequences.
REQ-002 The block SHALL have parameter N_SLICES, default 4, the number of slices per operation; TOT_W = SLICE_W*N_SLICES.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning operands a, b and c_in are offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts an operation this cycle.
REQ-007 The block SHALL have port a, input, TOT_W, the first operand.
REQ-008 The block SHALL have port b, input, TOT_W, the second operand.
REQ-009 The block SHALL have port c_in, input, 1, the carry-in.
REQ-010 The block SHALL have port out_valid, output, 1, meaning sum, c_out and err are valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-012 The block SHALL have port sum, output, TOT_W, the result a+b+c_in modulo 2^TOT_W.
REQ-013 The block SHALL have port c_out, output, 1, the carry-out of the full TOT_W addition.
REQ-014 The block SHALL have port err, output, 1, meaning the slice self-check failed at least once during the operation.

Function
REQ-015 The block SHALL instantiate exactly one sdb of width SLICE_W and drive its a, b, c_in and p (p = a_slice ^ b_slice) from internal registers only.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; reset state IDLE.
REQ-017 in_ready SHALL be 1 in IDLE only; an accept is in_valid & in_ready at a rising edge.
REQ-018 On accept the block SHALL capture a, b and c_in into operand registers, clear the slice counter, the sum register and err, and go to RUN; input changes after accept SHALL be ignored.
REQ-019 In RUN with slice counter k (0..N_SLICES-1), the sdb SHALL see bits [k*SLICE_W +: SLICE_W] of the captured operands, with the carry register as c_in (captured c_in for k=0).
REQ-020 At each RUN edge the block SHALL store s1 into sum bits [k*SLICE_W +: SLICE_W], load c_out_1 into the carry register and increment k.
REQ-021 At each RUN edge err SHALL be set (sticky) if c_out_1 != c_out_2 or s1 != ~s2.
REQ-022 At the RUN edge with k = N_SLICES-1 the FSM SHALL go to DONE, with c_out equal to the final carry; k SHALL not wrap past N_SLICES-1.
REQ-023 out_valid SHALL be 1 in DONE only; it rises exactly N_SLICES edges after the accept edge.
REQ-024 sum, c_out and err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 In DONE, out_ready=1 at an edge SHALL return the FSM to IDLE; in_valid in that same cycle SHALL not be accepted (in_ready=0).
REQ-026 in_valid in RUN or DONE SHALL be ignored and SHALL not disturb the operation in progress.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, k=0, carry register 0, sum=0, c_out=0, err=0, out_valid=0 and in_ready=0 while asserted; in_ready SHALL be 1 from the first edge after release.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid SHALL appear for it after release.

Verification
REQ-029 Default params, a=0xFFFFFFFF, b=0, c_in=1 -> out_valid 4 edges after accept, sum=0x00000000, c_out=1, err=0.
REQ-030 a=0x12345678, b=0x0FEDCBA9, c_in=0 -> sum=0x22222221, c_out=0, err=0; in_ready=0 until out_ready handshake.
REQ-031 out_ready held 0 for 10 cycles in DONE, a/b/in_valid toggled randomly -> sum, c_out, err unchanged, no new accept.
REQ-032 rst_n pulsed low during RUN at k=2 -> outputs zero immediately, in_ready=1 one edge after release, next operation correct.
REQ-033 Back-to-back: in_valid held 1 with out_ready=1 -> accepts occur every N_SLICES+2 edges, results match a+b+c_in.
REQ-034 1000 random operands -> {c_out,sum} == a+b+c_in every time, err=0.
